pavan_pulse_sync_arbiter: RTL and testbench
===========================================

Name: pavan_pulse_sync_arbiter

Overview:
- Source-domain (clk_a) scheduler that shares one handshake pulse synchronizer among N_REQ pulse requesters.
- Queues request pulses per requester in saturating pending counters and grants them round-robin.
- Issues one single-cycle pulse to the synchronizer's pulse input per grant, then follows the synchronizer's busy signal through the full request/acknowledge round trip before the next grant.
- Holds the granted requester ID stable for the whole transfer, so destination logic can sample it as quasi-static data.

Parameters:
N_REQ, 4, number of requesters (2..16)
CNT_W, 4, pending-counter width per requester; saturates at 2^CNT_W-1
TIMEOUT, 15, max clk_a cycles in WAIT_HI for sync_busy to rise before flagging an error
ID_W, $clog2(N_REQ), width of sel_id (derived, not overridden)

Ports:
clk_a  in  1  single clock, source domain; all logic on its rising edge
rst  in  1  synchronous, active-high reset
req_pulse  in  N_REQ  bit i high for one cycle = one event from requester i; multi-cycle high = one event per cycle
sync_busy  in  1  busy from the pulse synchronizer
sync_pulse  out  1  registered pulse to the synchronizer's pulse input
sel_valid  out  1  high while a transfer is in flight (ISSUE, WAIT_HI, WAIT_LO)
sel_id  out  ID_W  granted requester index; stable while sel_valid=1
done  out  N_REQ  one-cycle pulse on bit sel_id when a transfer completes
pend_nz  out  N_REQ  bit i = pending counter i nonzero
pend_ovf  out  N_REQ  sticky; request dropped at saturation
timeout_err  out  1  sticky; sync_busy never rose within TIMEOUT cycles

Behaviour:
- Reset (synchronous, at the rising edge with rst=1):
  - All outputs, counters and sticky flags go to 0; FSM goes to IDLE.
  - Round-robin pointer last_grant goes to N_REQ-1, so requester 0 has first priority.
  - rst overrides everything, mid-transfer included: sync_pulse is 0 after that edge, and the aborted transfer produces no done pulse.
- Pending counters, per i:
  - +1 on req_pulse[i]; -1 when i is granted (ISSUE entry).
  - Increment and decrement in the same cycle: count unchanged.
  - Increment at 2^CNT_W-1 with no decrement: count holds, the event is dropped, and pend_ovf[i] sets.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE:
  - If any count is nonzero and sync_busy=0: pick the first nonzero index scanning last_grant+1, +2, ... with wrap modulo N_REQ.
  - Register that index into sel_id and last_grant, then go to ISSUE.
  - If sync_busy=1: stay in IDLE. No grant is made.
- ISSUE (exactly 1 cycle):
  - sync_pulse=1, sel_valid=1, counter[sel_id] decrements.
  - Next state is WAIT_HI; the timeout counter clears.
- WAIT_HI:
  - sync_pulse=0.
  - When sync_busy=1, go to WAIT_LO.
  - Otherwise increment the timeout counter. At TIMEOUT: set timeout_err, go to IDLE, no done pulse; the consumed event is not restored.
- WAIT_LO:
  - While sync_busy=1, stay.
  - On sync_busy=0: done[sel_id]=1 for one cycle, sel_valid=0, go to IDLE.
  - A new grant can be made in that same IDLE cycle, giving a back-to-back spacing of 1 idle cycle.
- Latency: req_pulse sampled at edge k (FSM in IDLE, sync_busy=0):
  - count=1 after edge k.
  - ISSUE entered and sync_pulse=1 after edge k+1.
  - From request sample edge to pulse output: 2 cycles.
- Invariants:
  - sync_pulse is never asserted outside ISSUE.
  - At most one sync_pulse per transfer.
  - sel_id does not change while sel_valid=1.
- req_pulse arriving during a transfer only updates the counters. It is serviced by later grants in round-robin order, including for the currently granted requester.

Test Plan:
- Reset, then req_pulse=4'b0001 for 1 cycle, with a sync model (busy rises 1 cycle after pulse, falls 6 cycles later):
  - sync_pulse high exactly 1 cycle, 2 cycles after the request edge.
  - sel_id=0 and sel_valid=1 through busy low.
  - done=4'b0001 once.
- req_pulse=4'b1111 for 1 cycle:
  - grants in order 0,1,2,3, each separated by a full busy round trip.
  - 4 sync_pulses and 4 done pulses; pend_nz=0 at end.
- Requester 2 pulses 20 times with sync_busy held 1 (CNT_W=4):
  - count saturates at 15 and pend_ovf=4'b0100.
  - After releasing busy, exactly 15 transfers for id 2.
- sync_busy tied 0, single request:
  - one sync_pulse, then timeout_err=1 after 15 WAIT_HI cycles.
  - FSM back in IDLE, no done pulse.
- Simultaneous req_pulse[1] in the ISSUE cycle of grant 1:
  - count[1] stays 1, and a second transfer for id 1 follows.
- rst asserted in WAIT_LO:
  - after that edge, all outputs are 0 and no done pulse.
  - A fresh request is granted to id 0 first.

Source files
------------

// File: rtl/pavan_pulse_sync_arbiter.sv
// Round-robin scheduler that shares one handshake pulse synchronizer among N_REQ
// pulse requesters, queuing events in saturating per-requester pending counters.
module pavan_pulse_sync_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic             clk_a,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             sync_busy,
    output logic             sync_pulse,
    output logic             sel_valid,
    output logic [ID_W-1:0]  sel_id,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] pend_nz,
    output logic [N_REQ-1:0] pend_ovf,
    output logic             timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q [N_REQ];
    logic [CNT_W-1:0]   cnt_d [N_REQ];
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    sel_id_q;
    logic               sync_pulse_q;
    logic               sel_valid_q;
    logic [N_REQ-1:0]   done_q;
    logic [N_REQ-1:0]   pend_ovf_q;
    logic               timeout_err_q;
    logic [TO_W-1:0]    to_cnt_q;

    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    scan_idx;
    logic               grant;
    logic [N_REQ-1:0]   dec_vec;
    logic [N_REQ-1:0]   ovf_set;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pend_nz[i] = |cnt_q[i];
        end
    end

    // Scan starts one past the last grant, so the most recently served requester is last.
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!pick_found && pend_nz[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    assign grant = (state_q == IDLE) && pick_found && !sync_busy;

    always_comb begin
        dec_vec = '0;
        if (grant) begin
            dec_vec[pick_id] = 1'b1;
        end
    end

    // A simultaneous event and grant cancel out; an event at saturation is dropped and flagged.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_pulse[i] && !dec_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!req_pulse[i] && dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            // NOTE: the pending counters are a handful of flops, not a RAM, so clearing them on reset is cheap and required.
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            state_q       <= IDLE;
            last_grant_q  <= ID_W'(N_REQ - 1);
            sel_id_q      <= '0;
            sync_pulse_q  <= 1'b0;
            sel_valid_q   <= 1'b0;
            done_q        <= '0;
            pend_ovf_q    <= '0;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_ovf_q   <= pend_ovf_q | ovf_set;
            sync_pulse_q <= 1'b0;
            done_q       <= '0;

            case (state_q)
                IDLE: begin
                    if (grant) begin
                        sel_id_q     <= pick_id;
                        last_grant_q <= pick_id;
                        sync_pulse_q <= 1'b1;
                        sel_valid_q  <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (sync_busy) begin
                        state_q <= WAIT_LO;
                    end else if (to_cnt_q == TO_LAST) begin
                        // The consumed event is deliberately not restored.
                        timeout_err_q <= 1'b1;
                        sel_valid_q   <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!sync_busy) begin
                        done_q[sel_id_q] <= 1'b1;
                        sel_valid_q      <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sync_pulse  = sync_pulse_q;
    assign sel_valid   = sel_valid_q;
    assign sel_id      = sel_id_q;
    assign done        = done_q;
    assign pend_ovf    = pend_ovf_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pavan_pulse_sync_arbiter.sv
// Directed bench for pavan_pulse_sync_arbiter with a behavioural handshake
// synchronizer model (busy rises after the pulse and falls six cycles later).
module tb_pavan_pulse_sync_arbiter;

    localparam int N_REQ = 4;

    logic             clk_a     = 1'b0;
    logic             rst       = 1'b1;
    logic [N_REQ-1:0] req_pulse = '0;
    logic             sync_busy = 1'b0;
    logic             sync_pulse;
    logic             sel_valid;
    logic [1:0]       sel_id;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] pend_nz;
    logic [N_REQ-1:0] pend_ovf;
    logic             timeout_err;

    pavan_pulse_sync_arbiter #(.N_REQ(N_REQ), .CNT_W(4), .TIMEOUT(15)) dut (
        .clk_a      (clk_a),
        .rst        (rst),
        .req_pulse  (req_pulse),
        .sync_busy  (sync_busy),
        .sync_pulse (sync_pulse),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .done       (done),
        .pend_nz    (pend_nz),
        .pend_ovf   (pend_ovf),
        .timeout_err(timeout_err)
    );

    always #5 clk_a = ~clk_a;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int dones    = 0;
    int viol     = 0;
    int grant_log [$];
    int pulse_cyc [$];
    logic [N_REQ-1:0] done_log [$];

    bit         model_en   = 1'b0;
    bit         busy_force = 1'b0;
    int         bcnt       = 0;
    logic       prev_valid = 1'b0;
    logic [1:0] prev_id    = '0;

    always @(posedge clk_a) cyc++;

    // Synchronizer model plus transfer logging, both on the falling edge.
    always @(negedge clk_a) begin
        if (!model_en) begin
            sync_busy = busy_force;
            bcnt      = 0;
        end else if (sync_pulse) begin
            sync_busy = 1'b1;
            bcnt      = 6;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) sync_busy = 1'b0;
        end else begin
            sync_busy = 1'b0;
        end
        if (sync_pulse) begin
            pulses++;
            grant_log.push_back(int'(sel_id));
            pulse_cyc.push_back(cyc);
        end
        if (done != '0) begin
            dones++;
            done_log.push_back(done);
        end
        if (sync_pulse && !sel_valid) viol++;
        if (sel_valid && prev_valid && sel_id !== prev_id) viol++;
        prev_valid = sel_valid;
        prev_id    = sel_id;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    task automatic do_reset();
        req_pulse = '0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int bound, input string name);
        int n = 0;
        while (dones < target && n < bound) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (dones < target) $display("FAIL %s_wait: done count %0d, required %0d", name, dones, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({sync_pulse, sel_valid, sel_id} !== 4'b0) $display("FAIL reset_ctrl: got %b required 0000", {sync_pulse, sel_valid, sel_id});
        else n_pass++;
        n_checks++;
        if ({done, pend_nz} !== 8'b0) $display("FAIL reset_vec: got %b required 00000000", {done, pend_nz});
        else n_pass++;
        n_checks++;
        if ({pend_ovf, timeout_err} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {pend_ovf, timeout_err});
        else n_pass++;
    endtask

    task automatic test_single();
        int pb = pulses;
        int db = dones;
        int n;
        model_en  = 1'b1;
        req_pulse = 4'b0001;
        tick(1);
        req_pulse = '0;
        n_checks++;
        if ({pend_nz, sync_pulse} !== 5'b0001_0) $display("FAIL single_count: got %b required 00010", {pend_nz, sync_pulse});
        else n_pass++;
        tick(1);
        n_checks++;
        if ({sync_pulse, sel_valid, sel_id, pend_nz} !== 8'b1100_0000) $display("FAIL single_issue: got %b required 11000000", {sync_pulse, sel_valid, sel_id, pend_nz});
        else n_pass++;
        tick(1);
        n_checks++;
        if ({sync_pulse, sel_valid} !== 2'b01) $display("FAIL single_pulse_width: got %b required 01", {sync_pulse, sel_valid});
        else n_pass++;
        n = 1;
        while (sel_valid && n < 50) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n != 7) $display("FAIL single_round_trip: %0d cycles, required 7", n);
        else n_pass++;
        n_checks++;
        if (done !== 4'b0001) $display("FAIL single_done: got %b required 0001", done);
        else n_pass++;
        tick(1);
        n_checks++;
        if (done !== 4'b0000) $display("FAIL single_done_width: got %b required 0000", done);
        else n_pass++;
        n_checks++;
        if (pulses - pb != 1 || dones - db != 1) $display("FAIL single_counts: pulses %0d dones %0d, required 1 1", pulses - pb, dones - db);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int pb, db, gb, lb;
        model_en = 1'b1;
        do_reset();
        pb = pulses; db = dones; gb = grant_log.size(); lb = done_log.size();
        req_pulse = 4'b1111;
        tick(1);
        req_pulse = '0;
        wait_dones(db + 4, 100, "rr");
        tick(1);
        n_checks++;
        if (pulses - pb != 4 || dones - db != 4) $display("FAIL rr_counts: pulses %0d dones %0d, required 4 4", pulses - pb, dones - db);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (grant_log.size() <= gb + j || grant_log[gb + j] != j) $display("FAIL rr_order_%0d: grant log size %0d, required id %0d", j, grant_log.size() - gb, j);
            else n_pass++;
            n_checks++;
            if (done_log.size() <= lb + j || done_log[lb + j] !== 4'(1 << j)) $display("FAIL rr_done_%0d: done log size %0d, required bit %0d", j, done_log.size() - lb, j);
            else n_pass++;
        end
        for (int j = 1; j < 4; j++) begin
            n_checks++;
            if (pulse_cyc.size() <= gb + j || pulse_cyc[gb + j] - pulse_cyc[gb + j - 1] != 8) $display("FAIL rr_spacing_%0d: pulse log size %0d, required spacing 8", j, pulse_cyc.size() - gb);
            else n_pass++;
        end
        n_checks++;
        if (pend_nz !== 4'b0000) $display("FAIL rr_pend_nz: got %b required 0000", pend_nz);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int pb, db, gb, bad;
        model_en   = 1'b0;
        busy_force = 1'b1;
        do_reset();
        pb = pulses; db = dones; gb = grant_log.size();
        req_pulse = 4'b0100;
        tick(20);
        req_pulse = '0;
        tick(1);
        n_checks++;
        if ({pend_ovf, pend_nz} !== 8'b0100_0100) $display("FAIL sat_flags: got %b required 01000100", {pend_ovf, pend_nz});
        else n_pass++;
        n_checks++;
        if (pulses - pb != 0 || sel_valid !== 1'b0) $display("FAIL sat_no_grant_busy: pulses %0d valid %b, required 0 0", pulses - pb, sel_valid);
        else n_pass++;
        model_en = 1'b1;
        wait_dones(db + 15, 400, "sat");
        tick(10);
        bad = 0;
        for (int j = gb; j < grant_log.size(); j++) if (grant_log[j] != 2) bad++;
        n_checks++;
        if (pulses - pb != 15 || dones - db != 15 || bad != 0) $display("FAIL sat_transfers: pulses %0d dones %0d wrong-id %0d, required 15 15 0", pulses - pb, dones - db, bad);
        else n_pass++;
        n_checks++;
        if ({pend_ovf, pend_nz} !== 8'b0100_0000) $display("FAIL sat_drained: got %b required 01000000", {pend_ovf, pend_nz});
        else n_pass++;
        do_reset();
        n_checks++;
        if (pend_ovf !== 4'b0000) $display("FAIL sat_ovf_reset: got %b required 0000", pend_ovf);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int pb, db, n;
        logic err_at15;
        model_en   = 1'b0;
        busy_force = 1'b0;
        do_reset();
        pb = pulses; db = dones;
        req_pulse = 4'b0001;
        tick(1);
        req_pulse = '0;
        tick(1);
        n_checks++;
        if (sync_pulse !== 1'b1) $display("FAIL to_issue: sync_pulse %b required 1", sync_pulse);
        else n_pass++;
        n = 0;
        err_at15 = 1'bx;
        while (sel_valid && n < 50) begin
            tick(1);
            n++;
            if (n == 15) err_at15 = timeout_err;
        end
        n_checks++;
        if (n != 16 || err_at15 !== 1'b0) $display("FAIL to_duration: exit after %0d cycles err@15=%b, required 16 0", n, err_at15);
        else n_pass++;
        n_checks++;
        if ({timeout_err, sel_valid} !== 2'b10) $display("FAIL to_flag: got %b required 10", {timeout_err, sel_valid});
        else n_pass++;
        tick(5);
        n_checks++;
        if (pulses - pb != 1 || dones - db != 0 || pend_nz !== 4'b0 || timeout_err !== 1'b1) $display("FAIL to_after: pulses %0d dones %0d pend %b err %b, required 1 0 0000 1", pulses - pb, dones - db, pend_nz, timeout_err);
        else n_pass++;
        do_reset();
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL to_reset: got %b required 0", timeout_err);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int pb, db, gb;
        model_en = 1'b1;
        do_reset();
        pb = pulses; db = dones; gb = grant_log.size();
        req_pulse = 4'b0010;
        tick(1);
        tick(1);
        req_pulse = '0;
        n_checks++;
        if ({sync_pulse, sel_id, pend_nz} !== 7'b1_01_0010) $display("FAIL sim_grant: got %b required 1010010", {sync_pulse, sel_id, pend_nz});
        else n_pass++;
        wait_dones(db + 2, 100, "sim");
        tick(1);
        n_checks++;
        if (pulses - pb != 2 || grant_log.size() < gb + 2 || grant_log[gb] != 1 || grant_log[gb + 1] != 1) $display("FAIL sim_second: pulses %0d, required 2 transfers for id 1", pulses - pb);
        else n_pass++;
        n_checks++;
        if (pend_nz !== 4'b0000) $display("FAIL sim_pend: got %b required 0000", pend_nz);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int db, gb, n;
        model_en = 1'b1;
        do_reset();
        req_pulse = 4'b0001;
        tick(1);
        req_pulse = '0;
        tick(3);
        n_checks++;
        if ({sel_valid, sync_busy} !== 2'b11) $display("FAIL rm_in_flight: valid/busy %b required 11", {sel_valid, sync_busy});
        else n_pass++;
        db = dones;
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({sync_pulse, sel_valid, sel_id, done, pend_nz} !== 12'b0) $display("FAIL rm_outputs: got %b required 0", {sync_pulse, sel_valid, sel_id, done, pend_nz});
        else n_pass++;
        rst = 1'b0;
        tick(10);
        n_checks++;
        if (dones - db != 0) $display("FAIL rm_no_done: dones %0d required 0", dones - db);
        else n_pass++;
        gb = grant_log.size();
        req_pulse = 4'b1001;
        tick(1);
        req_pulse = '0;
        n = 0;
        while (!sync_pulse && n < 20) begin
            tick(1);
            n++;
        end
        n_checks++;
        if ({sync_pulse, sel_id} !== 3'b100) $display("FAIL rm_first_grant: pulse/id %b required 100", {sync_pulse, sel_id});
        else n_pass++;
        wait_dones(db + 2, 100, "rm");
        n_checks++;
        if (grant_log.size() < gb + 2 || grant_log[gb] != 0 || grant_log[gb + 1] != 3) $display("FAIL rm_order: grants %0d, required ids 0 then 3", grant_log.size() - gb);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        tick(2);
        n_checks++;
        if (viol != 0) $display("FAIL invariants: %0d violations, required 0", viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
